// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the BCD scan counter slice.
//   BCD_W   : width of one BCD digit code
//   BCD_MAX : largest legal BCD code (a decade wraps after this value)
//   onehot  : one-hot digit enable generator for the scanned display bus
package seg_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Returns a vector with only bit idx set, or all zeros if idx is out of range for n digits.
  function automatic logic [63:0] onehot(input int unsigned idx, input int unsigned n);
    logic [63:0] v;
    v = 64'd0;
    if ((idx < n) && (idx < 32'd64)) begin
      v[idx] = 1'b1;
    end else begin
      v = 64'd0;
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// bcd_decade: one decimal decade of the event counter.
//   clk   in  : rising-edge clock
//   rst_n in  : synchronous active-low reset, clears the digit
//   clr   in  : synchronous clear, wins over cin
//   cin   in  : carry in; the digit advances by one when high
//   q     out : current digit value, always within 0..9
//   cout  out : carry out, high when cin is high and the digit is at 9
module bcd_decade
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  logic [BCD_W-1:0] q_r;

  // Digit register: reset/clear to 0, advance on carry-in, wrap 9 -> 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= 4'd0;
    end else if (clr) begin
      q_r <= 4'd0;
    end else if (cin) begin
      if (q_r == BCD_MAX) begin
        q_r <= 4'd0;
      end else begin
        q_r <= q_r + 4'd1;
      end
    end else begin
      q_r <= q_r;
    end
  end

  // Combinational carry so a wrap ripples through every decade in one cycle.
  assign cout = cin & (q_r == BCD_MAX);
  assign q    = q_r;

endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: multi-digit BCD event counter with a time-multiplexed
// digit scanner feeding a common-bus 7-segment decoder.
//   clk       in  : rising-edge clock
//   rst_n     in  : synchronous active-low reset
//   inc       in  : count +1 on each edge where high
//   clr       in  : synchronous clear of the count, priority over inc
//   bcd_o     out : BCD code of the currently selected digit (registered)
//   dig_sel_o out : one-hot digit enable, bit 0 = least significant (registered)
//   blank_o   out : selected digit is a leading zero (registered)
//   ovf_o     out : one-cycle pulse after the count wraps all-9s -> all-0s
module bcd_scan_counter
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int LZB      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [BCD_W-1:0]  bcd_o,
  output logic [DIGITS-1:0] dig_sel_o,
  output logic              blank_o,
  output logic              ovf_o
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIGITS:0]    carry_s;
  logic [BCD_W-1:0]   digit_s [DIGITS];
  logic [PRE_W-1:0]   pre_r;
  logic [IDX_W-1:0]   scan_idx_r;
  logic [DIGITS-1:0]  sel_s;
  logic [DIGITS-1:0]  zero_above_s;
  logic               zero_acc_s;
  logic [BCD_W-1:0]   sel_bcd_s;
  logic               blank_s;
  logic [BCD_W-1:0]   bcd_r;
  logic [DIGITS-1:0]  dig_sel_r;
  logic               blank_r;
  logic               ovf_r;

  assign carry_s[0] = inc;

  // Counter decades, carry chained least significant first.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_decade u_decade (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .cin   (carry_s[g]),
      .q     (digit_s[g]),
      .cout  (carry_s[g+1])
    );
  end

  // Prescaler and scan index: index advances once every SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_r      <= {PRE_W{1'b0}};
      scan_idx_r <= {IDX_W{1'b0}};
    end else if (pre_r == PRE_LAST) begin
      pre_r      <= {PRE_W{1'b0}};
      scan_idx_r <= (scan_idx_r == IDX_LAST) ? {IDX_W{1'b0}} : scan_idx_r + IDX_W'(1);
    end else begin
      pre_r      <= pre_r + PRE_W'(1);
      scan_idx_r <= scan_idx_r;
    end
  end

  assign sel_s = DIGITS'(onehot(32'(scan_idx_r), DIGITS));

  // Digit mux and leading-zero map; zero_above_s[i] means digit i and all above are 0.
  always_comb begin
    sel_bcd_s    = {BCD_W{1'b0}};
    zero_acc_s   = 1'b1;
    zero_above_s = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_acc_s      = zero_acc_s & (digit_s[i] == 4'd0);
      zero_above_s[i] = zero_acc_s;
      sel_bcd_s       = sel_bcd_s | (digit_s[i] & {BCD_W{sel_s[i]}});
    end
    // Digit 0 is masked out so a zero count still shows a single 0.
    blank_s = (LZB != 0) && (|(sel_s & zero_above_s & ~DIGITS'(1)));
  end

  // Output registers: bcd/dig_sel/blank load together so the bus never glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_r     <= 4'd0;
      dig_sel_r <= DIGITS'(1);
      blank_r   <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      bcd_r     <= sel_bcd_s;
      dig_sel_r <= sel_s;
      blank_r   <= blank_s;
      // A carry out of the top decade is the wrap; clear suppresses it.
      ovf_r     <= carry_s[DIGITS] & ~clr;
    end
  end

  assign bcd_o     = bcd_r;
  assign dig_sel_o = dig_sel_r;
  assign blank_o   = blank_r;
  assign ovf_o     = ovf_r;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: directed self-checking bench for bcd_scan_counter
// with DIGITS=4, SCAN_DIV=4, LZB=1. Counts are written d3d2d1d0 in hex-coded BCD.
module tb_bcd_scan_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] bcd_o;
  logic [3:0] dig_sel_o;
  logic       blank_o;
  logic       ovf_o;

  int errors = 0;
  int checks = 0;

  logic [3:0] cap_bcd   [16];
  logic [3:0] cap_sel   [16];
  logic       cap_blank [16];

  bcd_scan_counter #(.DIGITS(4), .SCAN_DIV(4), .LZB(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (inc),
    .clr       (clr),
    .bcd_o     (bcd_o),
    .dig_sel_o (dig_sel_o),
    .blank_o   (blank_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk = ~clk;

  // Sample/drive point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_count();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic count_up(input int n);
    inc = 1'b1;
    repeat (n) tick();
    inc = 1'b0;
  endtask

  // Align to the start of a full scan (1000 -> 0001) and record 16 samples.
  task automatic scan_capture();
    logic [3:0] prev;
    logic       ok;
    ok = 1'b0;
    prev = dig_sel_o;
    for (int t = 0; t < 64 && !ok; t++) begin
      tick();
      if (prev == 4'b1000 && dig_sel_o == 4'b0001) ok = 1'b1;
      else prev = dig_sel_o;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL scan_sync: no 1000->0001 step in 64 cycles, dig_sel_o=%b", dig_sel_o);
    end
    for (int k = 0; k < 16; k++) begin
      cap_bcd[k] = bcd_o;
      cap_sel[k] = dig_sel_o;
      cap_blank[k] = blank_o;
      if (k < 15) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bcd_o !== 4'd0) begin errors++; $display("FAIL reset_bcd: got %0d want 0", bcd_o); end
    checks++; if (dig_sel_o !== 4'b0001) begin errors++; $display("FAIL reset_sel: got %b want 0001", dig_sel_o); end
    checks++; if (blank_o !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b want 0", blank_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_count_scan();
    logic [15:0] exp_cnt;
    logic [3:0]  bmask;
    logic [3:0]  e_bcd;
    logic [3:0]  e_sel;
    int          idx;
    count_up(123);
    exp_cnt = 16'h0123;
    bmask = 4'b1000;
    scan_capture();
    for (int k = 0; k < 16; k++) begin
      idx = k / 4;
      e_bcd = 4'((exp_cnt >> (4 * idx)) & 16'h000f);
      e_sel = 4'b0001 << idx;
      checks++;
      if ({cap_bcd[k], cap_sel[k], cap_blank[k]} !== {e_bcd, e_sel, bmask[idx]}) begin
        errors++;
        $display("FAIL scan_0123[%0d]: got bcd=%0d sel=%b blank=%b want bcd=%0d sel=%b blank=%b",
                 k, cap_bcd[k], cap_sel[k], cap_blank[k], e_bcd, e_sel, bmask[idx]);
      end
    end
  endtask

  task automatic test_carry_ripple();
    logic [15:0] exp_cnt;
    logic [3:0]  bmask;
    logic [3:0]  e_bcd;
    logic [3:0]  e_sel;
    int          idx;
    clear_count();
    count_up(99);
    count_up(1);
    exp_cnt = 16'h0100;
    bmask = 4'b1000;
    scan_capture();
    for (int k = 0; k < 16; k++) begin
      idx = k / 4;
      e_bcd = 4'((exp_cnt >> (4 * idx)) & 16'h000f);
      e_sel = 4'b0001 << idx;
      checks++;
      if ({cap_bcd[k], cap_sel[k], cap_blank[k]} !== {e_bcd, e_sel, bmask[idx]}) begin
        errors++;
        $display("FAIL carry_0100[%0d]: got bcd=%0d sel=%b blank=%b want bcd=%0d sel=%b blank=%b",
                 k, cap_bcd[k], cap_sel[k], cap_blank[k], e_bcd, e_sel, bmask[idx]);
      end
    end
  endtask

  task automatic test_wrap();
    int          ovf_count;
    int          ovf_at;
    logic [15:0] exp_cnt;
    logic [3:0]  bmask;
    logic [3:0]  e_bcd;
    logic [3:0]  e_sel;
    int          idx;
    clear_count();
    ovf_count = 0;
    ovf_at = -1;
    inc = 1'b1;
    // 9999 increments reach 9999, the 10000th wraps to 0000.
    for (int i = 1; i <= 10000; i++) begin
      tick();
      if (ovf_o === 1'b1) begin
        ovf_count++;
        ovf_at = i;
      end
    end
    inc = 1'b0;
    checks++;
    if (ovf_count != 1 || ovf_at != 10000) begin
      errors++;
      $display("FAIL wrap_ovf_pulse: got %0d pulses last at inc %0d want 1 pulse at inc 10000", ovf_count, ovf_at);
    end
    tick();
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL wrap_ovf_clear: got %b want 0", ovf_o); end
    exp_cnt = 16'h0000;
    bmask = 4'b1110;
    scan_capture();
    for (int k = 0; k < 16; k++) begin
      idx = k / 4;
      e_bcd = 4'((exp_cnt >> (4 * idx)) & 16'h000f);
      e_sel = 4'b0001 << idx;
      checks++;
      if ({cap_bcd[k], cap_sel[k], cap_blank[k]} !== {e_bcd, e_sel, bmask[idx]}) begin
        errors++;
        $display("FAIL wrap_0000[%0d]: got bcd=%0d sel=%b blank=%b want bcd=%0d sel=%b blank=%b",
                 k, cap_bcd[k], cap_sel[k], cap_blank[k], e_bcd, e_sel, bmask[idx]);
      end
    end
  endtask

  task automatic test_clr_priority();
    logic [15:0] exp_cnt;
    logic [3:0]  bmask;
    logic [3:0]  e_bcd;
    logic [3:0]  e_sel;
    int          idx;
    clear_count();
    count_up(42);
    clr = 1'b1;
    inc = 1'b1;
    tick();
    clr = 1'b0;
    inc = 1'b0;
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", ovf_o); end
    exp_cnt = 16'h0000;
    bmask = 4'b1110;
    scan_capture();
    for (int k = 0; k < 16; k++) begin
      idx = k / 4;
      e_bcd = 4'((exp_cnt >> (4 * idx)) & 16'h000f);
      e_sel = 4'b0001 << idx;
      checks++;
      if ({cap_bcd[k], cap_sel[k], cap_blank[k]} !== {e_bcd, e_sel, bmask[idx]}) begin
        errors++;
        $display("FAIL clr_0000[%0d]: got bcd=%0d sel=%b blank=%b want bcd=%0d sel=%b blank=%b",
                 k, cap_bcd[k], cap_sel[k], cap_blank[k], e_bcd, e_sel, bmask[idx]);
      end
    end
    // inc held high for 12 cycles counts once per cycle.
    count_up(12);
    exp_cnt = 16'h0012;
    bmask = 4'b1100;
    scan_capture();
    for (int k = 0; k < 16; k++) begin
      idx = k / 4;
      e_bcd = 4'((exp_cnt >> (4 * idx)) & 16'h000f);
      e_sel = 4'b0001 << idx;
      checks++;
      if ({cap_bcd[k], cap_sel[k], cap_blank[k]} !== {e_bcd, e_sel, bmask[idx]}) begin
        errors++;
        $display("FAIL held_0012[%0d]: got bcd=%0d sel=%b blank=%b want bcd=%0d sel=%b blank=%b",
                 k, cap_bcd[k], cap_sel[k], cap_blank[k], e_bcd, e_sel, bmask[idx]);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic found;
    clear_count();
    count_up(5678);
    found = 1'b0;
    for (int t = 0; t < 32 && !found; t++) begin
      tick();
      if (dig_sel_o == 4'b0100) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_sync: dig_sel_o never 0100, got %b", dig_sel_o); end
    checks++; if (bcd_o !== 4'd6) begin errors++; $display("FAIL mid_digit2: got %0d want 6", bcd_o); end
    rst_n = 1'b0;
    tick();
    checks++; if (bcd_o !== 4'd0) begin errors++; $display("FAIL mid_rst_bcd: got %0d want 0", bcd_o); end
    checks++; if (dig_sel_o !== 4'b0001) begin errors++; $display("FAIL mid_rst_sel: got %b want 0001", dig_sel_o); end
    checks++; if (blank_o !== 1'b0) begin errors++; $display("FAIL mid_rst_blank: got %b want 0", blank_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf: got %b want 0", ovf_o); end
    rst_n = 1'b1;
    // Four edges on digit 0, then digit 1 (a leading zero after reset).
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (k <= 4) begin
        if ({bcd_o, dig_sel_o, blank_o} !== {4'd0, 4'b0001, 1'b0}) begin
          errors++;
          $display("FAIL mid_hold[%0d]: got bcd=%0d sel=%b blank=%b want bcd=0 sel=0001 blank=0",
                   k, bcd_o, dig_sel_o, blank_o);
        end
      end else begin
        if ({bcd_o, dig_sel_o, blank_o} !== {4'd0, 4'b0010, 1'b1}) begin
          errors++;
          $display("FAIL mid_advance: got bcd=%0d sel=%b blank=%b want bcd=0 sel=0010 blank=1",
                   bcd_o, dig_sel_o, blank_o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_scan();
    test_carry_ripple();
    test_wrap();
    test_clr_priority();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the whole run needs well under 20k cycles.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
